// File: rtl/sram_allocator_pkg.sv
// Shared sizes, port FSM states and page arithmetic
// for the packet SRAM allocator.
package sram_allocator_pkg;

    localparam int unsigned NUM_PORTS = 16;
    localparam int unsigned NUM_SRAMS = 32;
    localparam int unsigned AMT_W     = 11;
    localparam int unsigned SRAM_W    = $clog2(NUM_SRAMS);
    localparam int unsigned DEST_W    = $clog2(NUM_PORTS);
    localparam int unsigned LEN_W     = 9;
    localparam int unsigned PAGE_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GRANT = 2'd2
    } port_state_e;

    // A page holds eight 16-bit words.
    function automatic logic [PAGE_W-1:0] calc_pages(
        input logic [LEN_W-1:0] len
    );
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(7);
        return PAGE_W'(sum >> 3);
    endfunction

endpackage

// File: rtl/alloc_port_fsm.sv
// One ingress port: fast rebind or 32-slot scan for
// the best SRAM, with lock set/clear requests.
module alloc_port_fsm
    import sram_allocator_pkg::*;
#(
    parameter int unsigned PORT_IDX = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [SRAM_W-1:0]                    cnt_i,
    input  logic                                 req_i,
    input  logic [DEST_W-1:0]                    dest_i,
    input  logic [LEN_W-1:0]                     len_i,
    input  logic                                 release_i,
    input  logic [NUM_SRAMS*AMT_W-1:0]           free_space_i,
    input  logic [NUM_SRAMS*NUM_PORTS*AMT_W-1:0] port_amount_i,
    input  logic [NUM_SRAMS-1:0]                 locking_i,
    output logic                                 grant_o,
    output logic [SRAM_W-1:0]                    grant_sram_o,
    output logic                                 bound_o,
    output logic                                 no_space_o,
    output logic [NUM_SRAMS-1:0]                 lock_set_o,
    output logic [NUM_SRAMS-1:0]                 lock_clr_o
);

    // Staggered offsets keep ports on distinct SRAMs each cycle.
    localparam logic [SRAM_W-1:0] OFFS = SRAM_W'(2 * PORT_IDX);

    port_state_e       state_q;
    logic              grant_q;
    logic              no_space_q;
    logic              bound_q;
    logic [SRAM_W-1:0] grant_sram_q;
    logic [DEST_W-1:0] bind_dest_q;
    logic [SRAM_W-1:0] best_q;
    logic [AMT_W-1:0]  best_amt_q;
    logic              best_valid_q;
    logic [SRAM_W-1:0] exam_q;

    logic [PAGE_W-1:0] pages;
    logic [SRAM_W-1:0] slot;
    logic [AMT_W-1:0]  slot_free;
    logic [AMT_W-1:0]  slot_amt;
    logic [AMT_W-1:0]  own_free;
    logic              slot_elig;
    logic              take;
    logic              fast_ok;

    assign pages     = calc_pages(len_i);
    assign slot      = cnt_i + OFFS;
    assign slot_free = free_space_i[int'(slot)*AMT_W +: AMT_W];
    assign slot_amt  = port_amount_i[
        (int'(slot)*NUM_PORTS + int'(dest_i))*AMT_W +: AMT_W];
    assign own_free  = free_space_i[int'(grant_sram_q)*AMT_W +: AMT_W];

    assign slot_elig = (!locking_i[slot]
                        || (bound_q && grant_sram_q == slot))
                       && slot_free >= AMT_W'(pages);

    assign take = (state_q == ST_SCAN) && slot_elig
                  && (!best_valid_q || slot_amt > best_amt_q);

    assign fast_ok = bound_q && bind_dest_q == dest_i
                     && own_free >= AMT_W'(pages);

    always_comb begin
        lock_set_o = '0;
        lock_clr_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bound_q && ((req_i && !fast_ok)
                                || (!req_i && release_i)))
                    lock_clr_o[grant_sram_q] = 1'b1;
            end
            ST_SCAN: begin
                if (take) begin
                    lock_set_o[slot] = 1'b1;
                    if (best_valid_q)
                        lock_clr_o[best_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            no_space_q   <= 1'b0;
            bound_q      <= 1'b0;
            grant_sram_q <= '0;
            bind_dest_q  <= '0;
            best_q       <= '0;
            best_amt_q   <= '0;
            best_valid_q <= 1'b0;
            exam_q       <= '0;
        end else begin
            grant_q    <= 1'b0;
            no_space_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        if (fast_ok) begin
                            best_q  <= grant_sram_q;
                            state_q <= ST_GRANT;
                        end else begin
                            bound_q      <= 1'b0;
                            best_valid_q <= 1'b0;
                            exam_q       <= '0;
                            state_q      <= ST_SCAN;
                        end
                    end else if (release_i && bound_q) begin
                        bound_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    exam_q <= exam_q + 1'b1;
                    if (take) begin
                        best_q       <= slot;
                        best_amt_q   <= slot_amt;
                        best_valid_q <= 1'b1;
                    end
                    if (exam_q == '1) begin
                        if (take || best_valid_q)
                            state_q <= ST_GRANT;
                        else
                            no_space_q <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    grant_q      <= 1'b1;
                    grant_sram_q <= best_q;
                    bind_dest_q  <= dest_i;
                    bound_q      <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign grant_sram_o = grant_sram_q;
    assign bound_o      = bound_q;
    assign no_space_o   = no_space_q;

endmodule

// File: rtl/sram_allocator.sv
// Binds shared packet SRAMs to ingress write ports;
// owns the slot counter and the SRAM lock register.
module sram_allocator
    import sram_allocator_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 req_i,
    input  logic [NUM_PORTS*DEST_W-1:0]          req_dest_port_i,
    input  logic [NUM_PORTS*LEN_W-1:0]           req_length_i,
    input  logic [NUM_PORTS-1:0]                 release_i,
    input  logic [NUM_SRAMS*AMT_W-1:0]           free_space_i,
    input  logic [NUM_SRAMS*NUM_PORTS*AMT_W-1:0] port_amount_i,
    output logic [NUM_PORTS-1:0]                 grant_o,
    output logic [NUM_PORTS*SRAM_W-1:0]          grant_sram_o,
    output logic [NUM_PORTS-1:0]                 bound_o,
    output logic [NUM_SRAMS-1:0]                 locking_o,
    output logic [NUM_PORTS-1:0]                 no_space_o
);

    logic [SRAM_W-1:0]    cnt_q;
    logic [NUM_SRAMS-1:0] locking_q;
    logic [NUM_SRAMS-1:0] locking_d;
    logic [NUM_SRAMS-1:0] lock_set [NUM_PORTS];
    logic [NUM_SRAMS-1:0] lock_clr [NUM_PORTS];
    logic [NUM_SRAMS-1:0] set_any;
    logic [NUM_SRAMS-1:0] clr_any;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        alloc_port_fsm #(
            .PORT_IDX(p)
        ) u_port (
            .clk          (clk),
            .rst_n        (rst_n),
            .cnt_i        (cnt_q),
            .req_i        (req_i[p]),
            .dest_i       (req_dest_port_i[p*DEST_W +: DEST_W]),
            .len_i        (req_length_i[p*LEN_W +: LEN_W]),
            .release_i    (release_i[p]),
            .free_space_i (free_space_i),
            .port_amount_i(port_amount_i),
            .locking_i    (locking_q),
            .grant_o      (grant_o[p]),
            .grant_sram_o (grant_sram_o[p*SRAM_W +: SRAM_W]),
            .bound_o      (bound_o[p]),
            .no_space_o   (no_space_o[p]),
            .lock_set_o   (lock_set[p]),
            .lock_clr_o   (lock_clr[p])
        );
    end

    // Ports never set and clear the same bit in one cycle.
    always_comb begin
        set_any = '0;
        clr_any = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            set_any = set_any | lock_set[p];
            clr_any = clr_any | lock_clr[p];
        end
        locking_d = (locking_q & ~clr_any) | set_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            locking_q <= '0;
        end else begin
            cnt_q     <= cnt_q + 1'b1;
            locking_q <= locking_d;
        end
    end

    assign locking_o = locking_q;

endmodule
